fetch_stage: RTL

Instruction-fetch stage plus IF/ID pipeline register. It feeds the decode stage, whose op/funct fields drive the control unit. It owns the PC and issues requests on a variable-latency instruction-memory port. It applies branch/jump redirects that decode resolves from the control unit's branch/jump codes and the register-equality flag. The pipeline has no delay slot: a taken redirect flushes the instruction fetched behind it.

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/redirect_unit.sv | 42 ++++
 rtl/fetch_stage.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fetch_pkg
// Brief   : Shared types and constants for the instruction-fetch stage.
// Revision: 1.0 - initial release
// ============================================================================
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        FETCH    = 2'd1,
        BUFFERED = 2'd2,
        DISCARD  = 2'd3
    } fetch_state_e;

    localparam logic [1:0]  BRANCH_BEQ      = 2'b01;
    localparam logic [1:0]  BRANCH_BNE      = 2'b10;
    localparam int          JUMP_DIRECT_BIT = 0;
    localparam int          JUMP_REG_BIT    = 1;
    localparam int          JUMP_LINK_BIT   = 2;
    localparam logic [31:0] NOP_INSTR       = 32'h0;

endpackage
`default_nettype wire

// File: rtl/redirect_unit.sv
`default_nettype none
// ============================================================================
// Module  : redirect_unit
// Brief   : Resolves branch/jump redirects and their target for the fetch PC.
// Revision: 1.0 - initial release
// ============================================================================
module redirect_unit
    import fetch_pkg::*;
(
    input  logic        i_valid_d,
    input  logic        i_stall_d,
    input  logic [1:0]  i_branch_d,
    input  logic [1:0]  i_jump_d,
    input  logic        i_equal_d,
    input  logic [31:0] i_branch_target_d,
    input  logic [31:0] i_rs_data_d,
    input  logic [25:0] i_jump_index_d,
    input  logic [3:0]  i_pc_region_d,
    output logic        o_redirect,
    output logic [31:0] o_target
);

    logic w_take;

    assign w_take = ((i_branch_d == BRANCH_BEQ) &&  i_equal_d) ||
                    ((i_branch_d == BRANCH_BNE) && !i_equal_d);

    // A stalled decode must not redirect; it re-evaluates once released.
    assign o_redirect = i_valid_d && !i_stall_d &&
                        (w_take || i_jump_d[JUMP_DIRECT_BIT] || i_jump_d[JUMP_REG_BIT]);

    always_comb begin
        o_target = i_branch_target_d;
        if (i_jump_d[JUMP_REG_BIT]) begin
            o_target = i_rs_data_d;
        end else if (i_jump_d[JUMP_DIRECT_BIT]) begin
            o_target = {i_pc_region_d, i_jump_index_d, 2'b00};
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module  : fetch_stage
// Brief   : PC, variable-latency imem fetch FSM and IF/ID pipeline register.
// Revision: 1.0 - initial release
// ============================================================================
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        stall_d_i,
    input  logic [1:0]  branch_d_i,
    input  logic [2:0]  jump_d_i,
    input  logic        equal_d_i,
    input  logic [31:0] branch_target_d_i,
    input  logic [31:0] rs_data_d_i,
    output logic [31:0] instr_d_o,
    output logic [31:0] pc_plus4_d_o,
    output logic        valid_d_o
);

    fetch_state_e r_state;
    fetch_state_e w_state_next;
    logic [31:0]  r_pc_f;
    logic [31:0]  r_addr_q;
    logic [31:0]  r_buf_instr;
    logic [31:0]  r_instr_d;
    logic [31:0]  r_pc_plus4_d;
    logic         r_valid_d;
    logic         w_redirect;
    logic [31:0]  w_target;
    logic         w_accept;
    logic [31:0]  w_pc_plus4_f;
    logic         w_unused_link;

    assign w_accept      = !stall_d_i || !r_valid_d;
    assign w_pc_plus4_f  = r_pc_f + 32'd4;
    // The link value is pc_plus4_d_o, written back downstream.
    assign w_unused_link = jump_d_i[JUMP_LINK_BIT];

    redirect_unit u_redirect (
        .i_valid_d         (r_valid_d),
        .i_stall_d         (stall_d_i),
        .i_branch_d        (branch_d_i),
        .i_jump_d          (jump_d_i[1:0]),
        .i_equal_d         (equal_d_i),
        .i_branch_target_d (branch_target_d_i),
        .i_rs_data_d       (rs_data_d_i),
        .i_jump_index_d    (r_instr_d[25:0]),
        .i_pc_region_d     (r_pc_plus4_d[31:28]),
        .o_redirect        (w_redirect),
        .o_target          (w_target)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            BOOT:     w_state_next = FETCH;
            FETCH: begin
                if (w_redirect) begin
                    w_state_next = imem_ready_i ? FETCH : DISCARD;
                end else if (imem_ready_i && !w_accept) begin
                    w_state_next = BUFFERED;
                end
            end
            BUFFERED: begin
                if (w_redirect || !stall_d_i) begin
                    w_state_next = FETCH;
                end
            end
            DISCARD: begin
                if (imem_ready_i) begin
                    w_state_next = FETCH;
                end
            end
            default:  w_state_next = BOOT;
        endcase
    end

    // DISCARD keeps presenting the abandoned address until memory completes it.
    always_comb begin
        imem_req_o  = (r_state == FETCH) || (r_state == DISCARD);
        imem_addr_o = (r_state == DISCARD) ? r_addr_q : r_pc_f;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pc_f       <= RESET_PC;
            r_addr_q     <= RESET_PC;
            r_buf_instr  <= NOP_INSTR;
            r_instr_d    <= NOP_INSTR;
            r_pc_plus4_d <= 32'h0;
            r_valid_d    <= 1'b0;
        end else begin
            case (r_state)
                FETCH: begin
                    if (w_redirect) begin
                        r_pc_f    <= w_target;
                        r_instr_d <= NOP_INSTR;
                        r_valid_d <= 1'b0;
                        if (!imem_ready_i) begin
                            r_addr_q <= r_pc_f;
                        end
                    end else if (imem_ready_i) begin
                        r_pc_f <= w_pc_plus4_f;
                        if (w_accept) begin
                            r_instr_d    <= imem_rdata_i;
                            r_pc_plus4_d <= w_pc_plus4_f;
                            r_valid_d    <= 1'b1;
                        end else begin
                            r_buf_instr <= imem_rdata_i;
                        end
                    end else if (w_accept) begin
                        r_instr_d <= NOP_INSTR;
                        r_valid_d <= 1'b0;
                    end
                end
                BUFFERED: begin
                    if (w_redirect) begin
                        r_pc_f    <= w_target;
                        r_instr_d <= NOP_INSTR;
                        r_valid_d <= 1'b0;
                    end else if (!stall_d_i) begin
                        // pc_f already advanced past the buffered word
                        r_instr_d    <= r_buf_instr;
                        r_pc_plus4_d <= r_pc_f;
                        r_valid_d    <= 1'b1;
                    end
                end
                DISCARD: begin
                    if (w_accept) begin
                        r_instr_d <= NOP_INSTR;
                        r_valid_d <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign instr_d_o    = r_instr_d;
    assign pc_plus4_d_o = r_pc_plus4_d;
    assign valid_d_o    = r_valid_d;

endmodule
`default_nettype wire
